// File: rtl/q_mult_pkg.sv
// Shared fixed-point definitions: default Q-format, 32-bit saturation limits
// and the multiplier FSM encoding.
package q_mult_pkg;

   localparam int DEF_N = 32;
   localparam int DEF_Q = 16;

   localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
   localparam logic [31:0] SAT_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/q_sat32.sv
// Combinational arithmetic right shift of a W-bit signed value by Q bits,
// saturated to a signed 32-bit result.
module q_sat32
   import q_mult_pkg::*;
#(
   parameter int W = 64,
   parameter int Q = 16
) (
   input  logic [W-1:0] i_p,
   output logic [31:0]  o_r
);

   localparam logic signed [64:0] LIM_HI = 65'sd2147483647;
   localparam logic signed [64:0] LIM_LO = -65'sd2147483648;

   logic signed [64:0] w_ext;
   logic signed [64:0] w_shr;

   // Widen first so the shift and the limit compares are valid for any W <= 64.
   assign w_ext = {{(65-W){i_p[W-1]}}, i_p};
   assign w_shr = w_ext >>> Q;

   always_comb begin
      // NOTE: default assigned first so every path drives o_r and no latch is inferred.
      o_r = w_shr[31:0];
      if (w_shr > LIM_HI) begin
         o_r = SAT_MAX;
      end else if (w_shr < LIM_LO) begin
         o_r = SAT_MIN;
      end
   end

endmodule

// File: rtl/q_mult.sv
// Sequential signed Q-format multiplier: radix-2 shift-add on operand
// magnitudes, one multiplier bit per enabled cycle, saturated 32-bit output.
module q_mult
   import q_mult_pkg::*;
#(
   parameter int N = DEF_N,
   parameter int Q = DEF_Q
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ce,
   input  logic         input_vld,
   input  logic [N-1:0] multiplicand_din,
   input  logic [N-1:0] multiplier_din,
   output logic [31:0]  product_dout,
   output logic         product_dout_vld,
   output logic         product_end
);

   localparam int            CW   = $clog2(N) + 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t          r_state;
   state_t          w_state_nxt;
   logic            r_sign;
   logic [N-1:0]    r_mag_a;
   logic [N-1:0]    r_mag_b;
   logic [2*N-1:0]  r_acc;
   logic [CW-1:0]   r_cnt;
   logic [31:0]     r_dout;
   logic            r_vld;
   logic            r_end;

   logic            w_load;
   logic            w_step;
   logic            w_write;
   logic            w_last;
   logic            w_bit;
   logic [N-1:0]    w_mag_a;
   logic [N-1:0]    w_mag_b;
   logic [2*N-1:0]  w_addend;
   logic [2*N-1:0]  w_prod;
   logic [31:0]     w_sat;

   // N-bit unsigned magnitude: -2^(N-1) negates to 2^(N-1), which still fits.
   assign w_mag_a  = multiplicand_din[N-1] ? -multiplicand_din : multiplicand_din;
   assign w_mag_b  = multiplier_din[N-1]   ? -multiplier_din   : multiplier_din;
   assign w_bit    = |(r_mag_b & ({{(N-1){1'b0}}, 1'b1} << r_cnt));
   assign w_addend = {{N{1'b0}}, r_mag_a} << r_cnt;
   assign w_last   = (r_cnt == LAST);
   assign w_prod   = r_sign ? -r_acc : r_acc;

   q_sat32 #(
      .W (2*N),
      .Q (Q)
   ) u_sat (
      .i_p (w_prod),
      .o_r (w_sat)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_write     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (input_vld) begin
               w_load      = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            w_step = 1'b1;
            if (w_last) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_write     = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else if (ce) begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sign  <= 1'b0;
         r_mag_a <= '0;
         r_mag_b <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_dout  <= '0;
         r_vld   <= 1'b0;
         r_end   <= 1'b0;
      end else if (ce) begin
         if (w_load) begin
            r_sign  <= multiplicand_din[N-1] ^ multiplier_din[N-1];
            r_mag_a <= w_mag_a;
            r_mag_b <= w_mag_b;
            r_acc   <= '0;
            r_cnt   <= '0;
         end
         if (w_step) begin
            if (w_bit) begin
               r_acc <= r_acc + w_addend;
            end
            r_cnt <= r_cnt + CW'(1);
         end
         if (w_write) begin
            r_dout <= w_sat;
         end
         r_vld <= w_write;
         r_end <= w_step && w_last;
      end
   end

   assign product_dout     = r_dout;
   assign product_dout_vld = r_vld;
   assign product_end      = r_end;

endmodule

// File: tb/tb_q_mult.sv
// Bench for q_mult: cycle-level reference model with per-cycle compare,
// plus directed operations with hand-computed results and latencies.
module tb_q_mult;

   localparam int N = 32;
   localparam int Q = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ce = 1'b1;
   logic        input_vld = 1'b0;
   logic [31:0] a_in = '0;
   logic [31:0] b_in = '0;
   logic [31:0] product_dout;
   logic        product_dout_vld;
   logic        product_end;

   int total = 0;
   int bad   = 0;
   bit run_cmp = 1'b0;

   // Reference model state
   int          en_cnt = 0;
   int          m_due = 0;
   bit          m_busy = 1'b0;
   logic [31:0] m_val = '0;
   logic [31:0] exp_dout = '0;
   bit          exp_vld = 1'b0;
   bit          exp_end = 1'b0;

   q_mult #(.N(N), .Q(Q)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .ce               (ce),
      .input_vld        (input_vld),
      .multiplicand_din (a_in),
      .multiplier_din   (b_in),
      .product_dout     (product_dout),
      .product_dout_vld (product_dout_vld),
      .product_end      (product_end)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Exact signed product, floor shift, saturate to 32 bits.
   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
      longint p;
      longint r;
      p = longint'($signed(a)) * longint'($signed(b));
      r = p >>> Q;
      if (r > 64'sd2147483647)  return 32'h7FFF_FFFF;
      if (r < -64'sd2147483648) return 32'h8000_0000;
      return r[31:0];
   endfunction

   // Timing model: accepted start at enabled edge e -> end after e+N, vld after e+N+1.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_busy   = 1'b0;
            exp_dout = '0;
            exp_vld  = 1'b0;
            exp_end  = 1'b0;
         end else if (ce) begin
            bit nv;
            bit ne;
            en_cnt++;
            nv = m_busy && (en_cnt == m_due);
            ne = m_busy && (en_cnt == m_due - 1);
            if (nv) begin
               exp_dout = m_val;
               m_busy   = 1'b0;
            end else if (!m_busy && input_vld) begin
               m_busy = 1'b1;
               m_due  = en_cnt + N + 1;
               m_val  = model(a_in, b_in);
            end
            exp_vld = nv;
            exp_end = ne;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (run_cmp) begin
            check("cyc_vld",  64'(product_dout_vld), 64'(exp_vld));
            check("cyc_end",  64'(product_end),      64'(exp_end));
            check("cyc_dout", 64'(product_dout),     64'(exp_dout));
         end
      end
   end

   task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int gap, input bit inject);
      int cnt;
      a_in = a;
      b_in = b;
      input_vld = 1'b1;
      @(negedge clk);
      input_vld = 1'b0;
      a_in = ~a;
      b_in = 32'h0001_2345;
      cnt = 0;
      while (!product_dout_vld && cnt < 200) begin
         @(negedge clk);
         cnt++;
         if (inject && cnt == 5) begin
            input_vld = 1'b1;
            a_in = 32'h0001_0000;
            b_in = 32'h0005_0000;
         end
         if (inject && cnt == 6) input_vld = 1'b0;
         if (gap > 0 && cnt == 10) ce = 1'b0;
         if (gap > 0 && cnt == 10 + gap) ce = 1'b1;
      end
      check({name, "_lat"}, 64'(cnt), 64'(N + 1 + gap));
      check(name, 64'(product_dout), 64'(exp));
   endtask

   initial begin
      bit seen;
      repeat (2) @(negedge clk);
      check("rst_dout", 64'(product_dout), 64'h0);
      check("rst_vld",  64'(product_dout_vld), 64'h0);
      check("rst_end",  64'(product_end), 64'h0);
      rst_n = 1'b1;
      run_cmp = 1'b1;
      repeat (2) @(negedge clk);

      run_op("p1_5x2",    32'h0001_8000, 32'h0002_0000, 32'h0003_0000, 0, 1'b0);
      repeat (3) @(negedge clk);
      run_op("n1_5x2",    32'hFFFE_8000, 32'h0002_0000, 32'hFFFD_0000, 0, 1'b0);
      repeat (2) @(negedge clk);
      run_op("lsb_x_lsb", 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 0, 1'b0);
      repeat (2) @(negedge clk);
      run_op("floor_neg", 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 0, 1'b0);
      repeat (2) @(negedge clk);
      run_op("sat_pos",   32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_FFFF, 0, 1'b0);
      repeat (2) @(negedge clk);
      run_op("sat_neg",   32'h8000_0000, 32'h7FFF_0000, 32'h8000_0000, 0, 1'b0);
      repeat (2) @(negedge clk);
      run_op("min_x_min", 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 0, 1'b0);
      repeat (2) @(negedge clk);
      run_op("zero_op",   32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 0, 1'b0);
      repeat (2) @(negedge clk);
      run_op("ce_gap",    32'h0001_8000, 32'h0002_0000, 32'h0003_0000, 5, 1'b0);
      repeat (2) @(negedge clk);
      run_op("ignore_2nd", 32'hFFFE_8000, 32'h0002_0000, 32'hFFFD_0000, 0, 1'b1);
      run_op("back2back", 32'h0002_8000, 32'h0004_0000, 32'h000A_0000, 0, 1'b0);
      repeat (2) @(negedge clk);
      run_op("pre_reset", 32'h0001_8000, 32'h0002_0000, 32'h0003_0000, 0, 1'b0);

      // Abort an operation mid-RUN with an asynchronous reset.
      a_in = 32'h0002_0000;
      b_in = 32'h0002_0000;
      input_vld = 1'b1;
      @(negedge clk);
      input_vld = 1'b0;
      repeat (10) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_dout", 64'(product_dout), 64'h0);
      check("async_rst_vld",  64'(product_dout_vld), 64'h0);
      check("async_rst_end",  64'(product_end), 64'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         seen |= product_dout_vld;
      end
      check("no_vld_after_rst", 64'(seen), 64'h0);
      run_op("post_reset", 32'h0001_8000, 32'h0002_0000, 32'h0003_0000, 0, 1'b0);
      repeat (3) @(negedge clk);

      run_cmp = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
